// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register.
//   shreg_mode_t : 2-bit operating mode (HOLD, SHR, SHL, LOAD)
package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shreg_mode_t;

endpackage

// File: rtl/shift_word_counter.sv
// Mod-WIDTH shift-event counter with a registered wrap pulse.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   synchronous clear (highest priority)
//   load       in   parallel load happened; discards any partial word
//   step       in   one shift happened this edge
//   cnt        out  shifts completed in the current word
//   wrap_pulse out  high for the cycle after the WIDTH-th shift of a word
module shift_word_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap_pulse
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             wrap_d, wrap_q;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear || load) begin
      cnt_d = '0;
    end else if (step) begin
      if (cnt_q == LastCnt) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt        = cnt_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift-right, shift-left, parallel load, optional rotate,
// with a shift-event counter that pulses word_valid when a WIDTH-shift word completes.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   clear                 synchronous clear, overrides en and mode
//   en                    clock enable for mode operations
//   mode                  00 HOLD, 01 SHR, 10 SHL, 11 LOAD
//   rotate                shifted-out bit re-enters instead of the serial input
//   ser_in_r / ser_in_l   serial inputs entering MSB on SHR / LSB on SHL
//   par_in                parallel load data
//   q                     register contents
//   ser_out_r / ser_out_l q[0] / q[WIDTH-1]
//   cnt, word_valid       shifts in current word, one-cycle word-complete pulse
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CNT_W-1:0] cnt,
  output logic             word_valid
);

  shreg_mode_t      mode_e;
  logic [WIDTH-1:0] q_d, q_q;
  logic             shift, load;

  assign mode_e = shreg_mode_t'(mode);

  always_comb begin
    q_d   = q_q;
    shift = 1'b0;
    load  = 1'b0;
    if (clear) begin
      q_d = '0;
    end else if (en) begin
      case (mode_e)
        MODE_LOAD: begin
          q_d  = par_in;
          load = 1'b1;
        end
        MODE_SHR: begin
          q_d   = {(rotate ? q_q[0] : ser_in_r), q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        MODE_SHL: begin
          q_d   = {q_q[WIDTH-2:0], (rotate ? q_q[WIDTH-1] : ser_in_l)};
          shift = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // shift/load are already gated by clear and en, so the counter only sees real events.
  shift_word_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .load       (load),
    .step       (shift),
    .cnt        (cnt),
    .wrap_pulse (word_valid)
  );

  assign q         = q_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  int         checks = 0;
  int         errors = 0;

  // WIDTH=4 instance
  logic       clear = 1'b0, en = 1'b0, rotate = 1'b0, sir = 1'b0, sil = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] par_in = 4'h0;
  logic [3:0] q;
  logic       sor, sol, wv;
  logic [1:0] cnt;

  // WIDTH=8 instance
  logic       clear8 = 1'b0, en8 = 1'b0, sil8 = 1'b0;
  logic [1:0] mode8 = 2'b00;
  logic [7:0] par_in8 = 8'h00;
  logic [7:0] q8;
  logic       sor8, sol8, wv8;
  logic [2:0] cnt8;

  always #5 clock = ~clock;

  univ_shift_reg #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .clear(clear), .en(en), .mode(mode), .rotate(rotate),
    .ser_in_r(sir), .ser_in_l(sil), .par_in(par_in), .q(q), .ser_out_r(sor),
    .ser_out_l(sol), .cnt(cnt), .word_valid(wv)
  );

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .clear(clear8), .en(en8), .mode(mode8), .rotate(1'b0),
    .ser_in_r(1'b0), .ser_in_l(sil8), .par_in(par_in8), .q(q8), .ser_out_r(sor8),
    .ser_out_l(sol8), .cnt(cnt8), .word_valid(wv8)
  );

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (q !== 4'b0000 || cnt !== 2'd0 || wv !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: q=%b cnt=%0d wv=%b, expected 0000/0/0", q, cnt, wv);
    end
    @(negedge clock);
    reset = 1'b1;
    // Build q=1011, cnt=2: LOAD 1100, SHR 0, SHR 1.
    en = 1'b1; mode = 2'b11; par_in = 4'b1100;
    tick();
    mode = 2'b01; sir = 1'b0;
    tick();
    sir = 1'b1;
    tick();
    checks++;
    if (q !== 4'b1011 || cnt !== 2'd2) begin
      errors++;
      $display("FAIL reset_setup: q=%b cnt=%0d, expected 1011/2", q, cnt);
    end
    mode = 2'b00;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (q !== 4'b0000 || cnt !== 2'd0 || wv !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: q=%b cnt=%0d wv=%b, expected 0000/0/0", q, cnt, wv);
    end
    // Held across an edge even with a shift requested.
    mode = 2'b01; sir = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0000 || cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_held: q=%b cnt=%0d, expected 0000/0", q, cnt);
    end
    @(negedge clock);
    mode = 2'b00;
    reset = 1'b1;
  endtask

  task automatic test_shr();
    logic [3:0] exp_q  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [1:0] exp_c  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_wv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       ser    [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    en = 1'b1; mode = 2'b01; rotate = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sir = ser[i];
      tick();
      checks++;
      if (q !== exp_q[i] || cnt !== exp_c[i] || wv !== exp_wv[i]) begin
        errors++;
        $display("FAIL shr_%0d: q=%b cnt=%0d wv=%b, expected %b/%0d/%b",
                 i, q, cnt, wv, exp_q[i], exp_c[i], exp_wv[i]);
      end
    end
    checks++;
    if (sor !== 1'b1 || sol !== 1'b0) begin
      errors++;
      $display("FAIL shr_serout: ser_out_r=%b ser_out_l=%b, expected 1/0", sor, sol);
    end
    mode = 2'b00;
    tick();
    checks++;
    if (wv !== 1'b0 || q !== 4'b0001) begin
      errors++;
      $display("FAIL shr_pulse_end: wv=%b q=%b, expected 0/0001", wv, q);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_q  [4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
    logic       exp_wv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    mode = 2'b11; par_in = 4'b1011;
    tick();
    checks++;
    if (q !== 4'b1011 || cnt !== 2'd0 || wv !== 1'b0) begin
      errors++;
      $display("FAIL rot_load: q=%b cnt=%0d wv=%b, expected 1011/0/0", q, cnt, wv);
    end
    mode = 2'b10; rotate = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sil = ~sil;
      tick();
      checks++;
      if (q !== exp_q[i] || wv !== exp_wv[i]) begin
        errors++;
        $display("FAIL rot_%0d: q=%b wv=%b, expected %b/%b", i, q, wv, exp_q[i], exp_wv[i]);
      end
    end
    checks++;
    if (sol !== 1'b1 || cnt !== 2'd0) begin
      errors++;
      $display("FAIL rot_end: ser_out_l=%b cnt=%0d, expected 1/0", sol, cnt);
    end
    rotate = 1'b0;
  endtask

  task automatic test_enable();
    clear = 1'b1; mode = 2'b00;
    tick();
    clear = 1'b0;
    checks++;
    if (q !== 4'b0000 || cnt !== 2'd0 || wv !== 1'b0) begin
      errors++;
      $display("FAIL en_clear: q=%b cnt=%0d wv=%b, expected 0000/0/0", q, cnt, wv);
    end
    mode = 2'b01; sir = 1'b1;
    tick();
    tick();
    checks++;
    if (q !== 4'b1100 || cnt !== 2'd2) begin
      errors++;
      $display("FAIL en_pre: q=%b cnt=%0d, expected 1100/2", q, cnt);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 4'b1100 || cnt !== 2'd2 || wv !== 1'b0) begin
        errors++;
        $display("FAIL en_frozen_%0d: q=%b cnt=%0d wv=%b, expected 1100/2/0", i, q, cnt, wv);
      end
    end
    en = 1'b1; sir = 1'b0;
    tick();
    checks++;
    if (q !== 4'b0110 || cnt !== 2'd3 || wv !== 1'b0) begin
      errors++;
      $display("FAIL en_post3: q=%b cnt=%0d wv=%b, expected 0110/3/0", q, cnt, wv);
    end
    tick();
    checks++;
    if (q !== 4'b0011 || cnt !== 2'd0 || wv !== 1'b1) begin
      errors++;
      $display("FAIL en_post4: q=%b cnt=%0d wv=%b, expected 0011/0/1", q, cnt, wv);
    end
  endtask

  task automatic test_load_abort();
    mode = 2'b10; sil = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (q !== 4'b1000 || cnt !== 2'd3) begin
      errors++;
      $display("FAIL abort_pre: q=%b cnt=%0d, expected 1000/3", q, cnt);
    end
    mode = 2'b11; par_in = 4'b0110;
    tick();
    checks++;
    if (q !== 4'b0110 || cnt !== 2'd0 || wv !== 1'b0) begin
      errors++;
      $display("FAIL abort_load: q=%b cnt=%0d wv=%b, expected 0110/0/0", q, cnt, wv);
    end
    clear = 1'b1; par_in = 4'b1111;
    tick();
    clear = 1'b0;
    checks++;
    if (q !== 4'b0000 || cnt !== 2'd0 || wv !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: q=%b cnt=%0d wv=%b, expected 0000/0/0", q, cnt, wv);
    end
    mode = 2'b00;
  endtask

  task automatic test_width8();
    logic [7:0] exp_q = 8'h00;
    en8 = 1'b1; mode8 = 2'b10; sil8 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_q = {exp_q[6:0], 1'b1};
      checks++;
      if (q8 !== exp_q || wv8 !== (i == 8) || cnt8 !== 3'(i % 8)) begin
        errors++;
        $display("FAIL w8_%0d: q=%h cnt=%0d wv=%b, expected %h/%0d/%b",
                 i, q8, cnt8, wv8, exp_q, i % 8, (i == 8));
      end
    end
    en8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shr();
    test_rotate();
    test_enable();
    test_load_abort();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
